// File: rtl/synt_cal_pkg.sv
// Shared state encoding and default sizing for the RX synthesizer power-up / cap-bank calibration engine.
package synt_cal_pkg;

  localparam int CODE_W_DEF  = 6;
  localparam int PU_WAIT_DEF = 10;
  localparam int SETTLE_DEF  = 4;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_IDLE  = 3'd2,
    S_STEP  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/synt_cal_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear; output lags the input by two clock edges.
module synt_cal_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/synt_cal.sv
// Synthesizer power-up sequencer and MSB-first SAR search of the VCO coarse cap code.
// PU_WAIT cycles to IDLE, then CODE_W*(SETTLE+1) cycles per calibration; all outputs registered.
module synt_cal
  import synt_cal_pkg::*;
#(
  parameter int CODE_W  = CODE_W_DEF,
  parameter int PU_WAIT = PU_WAIT_DEF,
  parameter int SETTLE  = SETTLE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pu_synt,
  input  logic              i_cal_synt,
  input  logic              i_cmp_fast,
  output logic              o_en_vco,
  output logic              o_cmp_en,
  output logic [CODE_W-1:0] o_cap_code,
  output logic              o_busy,
  output logic              o_rdy_synt
);

  localparam int CNT_W = $clog2(max2(PU_WAIT, SETTLE) + 1);
  localparam int IDX_W = $clog2(CODE_W);
  localparam logic [CODE_W-1:0] MID = {1'b1, {(CODE_W-1){1'b0}}};

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [IDX_W-1:0]  r_idx, w_idx, w_idx_dn;
  logic [CODE_W-1:0] r_code, w_code;
  logic              r_en_vco, r_search, r_rdy;
  logic              w_cmp_sync;

  synt_cal_sync2 u_sync_cmp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_cmp_fast),
    .o_q     (w_cmp_sync)
  );

  assign w_idx_dn = r_idx - IDX_W'(1);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_code  = r_code;
    // Losing power overrides everything, including an active calibration request.
    if (!i_pu_synt) begin
      w_state = S_OFF;
      w_cnt   = '0;
      w_idx   = '0;
      w_code  = MID;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state = S_PWRUP;
          w_cnt   = CNT_W'(PU_WAIT - 1);
        end
        S_PWRUP: begin
          if (r_cnt == '0) w_state = S_IDLE;
          else             w_cnt   = r_cnt - CNT_W'(1);
        end
        S_IDLE: begin
          if (i_cal_synt) begin
            w_state = S_STEP;
            w_idx   = IDX_W'(CODE_W - 1);
            w_code  = MID;
          end
        end
        S_STEP: begin
          if (!i_cal_synt) begin
            w_state = S_IDLE;
            w_code  = MID;
          end else begin
            w_state = S_WAIT;
            w_cnt   = CNT_W'(SETTLE - 1);
          end
        end
        S_WAIT: begin
          if (!i_cal_synt) begin
            w_state = S_IDLE;
            w_code  = MID;
          end else if (r_cnt != '0) begin
            w_cnt = r_cnt - CNT_W'(1);
          end else begin
            // VCO still too fast keeps the added capacitance on this bit.
            w_code[r_idx] = w_cmp_sync;
            if (r_idx != '0) begin
              w_code[w_idx_dn] = 1'b1;
              w_idx            = w_idx_dn;
              w_state          = S_STEP;
            end else begin
              w_state = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!i_cal_synt) w_state = S_IDLE;
        end
        default: w_state = S_OFF;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_OFF;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_code   <= MID;
      r_en_vco <= 1'b0;
      r_search <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_idx    <= w_idx;
      r_code   <= w_code;
      r_en_vco <= (w_state != S_OFF);
      r_search <= (w_state == S_STEP) || (w_state == S_WAIT);
      r_rdy    <= (w_state == S_DONE);
    end
  end

  assign o_en_vco   = r_en_vco;
  assign o_cmp_en   = r_search;
  assign o_busy     = r_search;
  assign o_rdy_synt = r_rdy;
  assign o_cap_code = r_code;

endmodule

// File: tb/tb_synt_cal.sv
// Randomized scoreboard bench for synt_cal: a threshold comparator plant drives CMP_FAST from the cap code.
module tb_synt_cal;

  localparam int CW = 6;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          pu    = 1'b0;
  logic          cal   = 1'b0;
  logic          cmp   = 1'b0;
  logic          en_vco, cmp_en, busy, rdy;
  logic [CW-1:0] code;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int thr      = 0;
  int glitch_cyc = -1;
  int pu_cyc   = 0;
  int cal_cyc  = 0;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic rdy_q = 1'b0;

  synt_cal #(.CODE_W(CW), .PU_WAIT(10), .SETTLE(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pu_synt  (pu),
    .i_cal_synt (cal),
    .i_cmp_fast (cmp),
    .o_en_vco   (en_vco),
    .o_cmp_en   (cmp_en),
    .o_cap_code (code),
    .o_busy     (busy),
    .o_rdy_synt (rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Comparator plant: VCO is "fast" whenever the code is at or below the threshold.
  always @(negedge clk) cmp = ((int'(code) <= thr) ? 1'b1 : 1'b0) ^ ((cyc == glitch_cyc) ? 1'b1 : 1'b0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A monotone comparator makes the search land on the largest code it still calls fast.
  function automatic int exp_code(input int t);
    if (t < 0) return 0;
    if (t > (1 << CW) - 1) return (1 << CW) - 1;
    return t;
  endfunction

  // Edge on which the search starts: first IDLE edge that sees CAL_SYNT high.
  function automatic int e1();
    return ((cal_cyc > pu_cyc + 11) ? cal_cyc : pu_cyc + 11) + 1;
  endfunction

  task automatic push_exp(input int t);
    exp_t e;
    e.code = exp_code(t);
    e.cyc  = e1() + 30;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic power_up();
    pu     = 1'b1;
    pu_cyc = cyc;
  endtask

  task automatic cal_on(input int t, input bit expect_rdy);
    thr     = t;
    cal     = 1'b1;
    cal_cyc = cyc;
    if (expect_rdy) push_exp(t);
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rdy_timeout: got no RDY_SYNT within %0d cycles, required %0d pending results", budget, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_en_vco"}, en_vco, 0);
    chk({nm, "_cmp_en"}, cmp_en, 0);
    chk({nm, "_busy"},   busy,   0);
    chk({nm, "_rdy"},    rdy,    0);
    chk({nm, "_code"},   code,   32);
  endtask

  always @(negedge clk) begin
    if (rdy === 1'b1 && rdy_q !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy: got RDY_SYNT=1 code %0d at cycle %0d, required no result", code, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("cal_code",  code, mon_e.code);
        chk("rdy_cycle", cyc,  mon_e.cyc);
        chk("done_busy", {busy, cmp_en}, 0);
      end
    end
    rdy_q = rdy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #1 rst_n = 1'b0;
    #1;
    chk_reset("rst_init");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Nominal: request arrives while still powering up, honoured once IDLE.
    power_up();
    tick(10);
    cal_on(45, 1);
    wait_sb(60);
    cal = 1'b0;
    tick(1);
    chk("idle_rdy",  rdy,    0);
    chk("idle_code", code,   45);
    chk("idle_vco",  en_vco, 1);

    // Stuck comparators, random thresholds, one off-window glitch.
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       t = 1000;
        1:       t = -1;
        default: t = int'($urandom_range(63, 0));
      endcase
      cal_on(t, 1);
      if (i == 2) glitch_cyc = e1() + 11;
      wait_sb(60);
      glitch_cyc = -1;
      cal = 1'b0;
      tick(1);
      chk("recal_idle_rdy",  rdy,  0);
      chk("recal_idle_code", code, exp_code(t));
      chk("recal_idle_busy", busy, 0);
    end

    // Abort during the bit-3 settle window.
    cal_on(int'($urandom_range(63, 0)), 0);
    tick(13);
    chk("abort_pre_busy", busy, 1);
    cal = 1'b0;
    tick(1);
    chk("abort_code",   code,   32);
    chk("abort_busy",   busy,   0);
    chk("abort_rdy",    rdy,    0);
    chk("abort_cmp_en", cmp_en, 0);
    chk("abort_vco",    en_vco, 1);
    cal_on(int'($urandom_range(63, 0)), 1);
    wait_sb(60);

    // Power-down from DONE with CAL_SYNT left high, then re-power.
    pu = 1'b0;
    tick(1);
    chk("pd_vco",  en_vco, 0);
    chk("pd_rdy",  rdy,    0);
    chk("pd_code", code,   32);
    chk("pd_busy", busy,   0);
    tick(2);
    thr = int'($urandom_range(63, 0));
    power_up();
    push_exp(thr);
    for (int k = 0; k < 11; k++) begin
      tick(1);
      chk("early_cmp_en", cmp_en, 0);
      chk("pwrup_vco",    en_vco, 1);
    end
    tick(1);
    chk("search_start_cmp_en", cmp_en, 1);
    wait_sb(60);

    // Asynchronous reset in the middle of a search.
    cal = 1'b0;
    tick(1);
    cal_on(int'($urandom_range(63, 0)), 0);
    tick(8);
    chk("rst_pre_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    pu  = 1'b0;
    cal = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    power_up();
    cal_on(int'($urandom_range(63, 0)), 1);
    wait_sb(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
